mm_axis_packer: RTL and testbench

- Upstream neighbour of the matrix-multiply AXI wrapper.
- Accepts a stream of D_W-bit matrix elements, one per beat, and packs them little-endian into 32-bit words.
- Drives the multiplier's x stream (x_TDATA/x_TVALID/x_TREADY/x_TLAST) and asserts TLAST on the last word of each operand frame.
- Detects and reports malformed frames: early or missing source TLAST.

---
 rtl/mm_pkg.sv | 28 ++
 rtl/mm_axis_outreg.sv | 49 ++++
 rtl/mm_axis_packer.sv | 139 +++++++++++++
 tb/tb_mm_axis_packer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared constants and helpers for the matrix-multiply stream blocks.
// The element width and frame size defaults must match the downstream multiplier.
package mm_pkg;

  localparam int M           = 4;
  localparam int N           = 4;
  localparam int D_W         = 8;
  localparam int AXIS_W      = 32;
  localparam int LANES       = AXIS_W / D_W;
  localparam int FRAME_ELEMS = 2 * M * N;

  // One output beat: packed data plus its end-of-frame marker.
  typedef struct packed {
    logic              last;
    logic [AXIS_W-1:0] data;
  } axis_word_t;

  // Number of bits needed to encode the values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mm_axis_outreg.sv
// Single-entry valid/ready output register: holds its word while stalled and
// accepts a new load in the same cycle the current word is consumed.
module mm_axis_outreg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: every signal assigned in always_comb gets a default on entry, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mm_axis_packer.sv
// Packs a stream of D_W-bit matrix elements little-endian into 32-bit words,
// marks the last word of each operand frame and flags malformed frames.
module mm_axis_packer #(
  parameter int M           = mm_pkg::M,
  parameter int N           = mm_pkg::N,
  parameter int D_W         = mm_pkg::D_W,
  parameter int FRAME_ELEMS = 2 * M * N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [D_W-1:0] s_axis_tdata,
  input  logic           s_axis_tvalid,
  output logic           s_axis_tready,
  input  logic           s_axis_tlast,
  output logic [31:0]    x_TDATA,
  output logic           x_TVALID,
  input  logic           x_TREADY,
  output logic           x_TLAST,
  output logic           err_short,
  output logic           err_long,
  output logic [15:0]    frame_cnt
);

  import mm_pkg::*;

  localparam int N_LANES = AXIS_W / D_W;
  localparam int LANE_W  = (N_LANES > 1) ? clog2(N_LANES) : 1;
  localparam int CNT_W   = (FRAME_ELEMS > 1) ? clog2(FRAME_ELEMS) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(FRAME_ELEMS - 1);

  logic [LANE_W-1:0] lane_q,      lane_d;
  logic [CNT_W-1:0]  elem_cnt_q,  elem_cnt_d;
  logic [AXIS_W-1:0] asm_q,       asm_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q,  err_long_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              accept;
  logic              frame_end;
  logic              close;
  logic              close_last;
  logic [AXIS_W-1:0] merged;
  logic              out_ready_up;
  logic              out_valid;
  axis_word_t        load_word;
  axis_word_t        out_word;

  assign s_axis_tready = out_ready_up;
  assign accept        = s_axis_tvalid && out_ready_up;
  assign frame_end     = (elem_cnt_q == LAST_CNT);
  assign close_last    = frame_end || s_axis_tlast;
  assign close         = accept && ((lane_q == LAST_LANE) || close_last);

  // Lanes above the current one are still zero because the assembly register
  // is cleared on every close, which gives the zero padding of short words.
  always_comb begin
    merged = asm_q;
    for (int k = 0; k < N_LANES; k++) begin
      if (lane_q == LANE_W'(k)) begin
        merged[k*D_W +: D_W] = s_axis_tdata;
      end
    end
  end

  always_comb begin
    lane_d      = lane_q;
    elem_cnt_d  = elem_cnt_q;
    asm_d       = asm_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    frame_cnt_d = frame_cnt_q;

    if (accept) begin
      if (close) begin
        lane_d     = '0;
        asm_d      = '0;
        elem_cnt_d = close_last ? '0 : elem_cnt_q + 1'b1;
      end else begin
        lane_d     = lane_q + 1'b1;
        asm_d      = merged;
        elem_cnt_d = elem_cnt_q + 1'b1;
      end
      if (s_axis_tlast && !frame_end) begin
        err_short_d = 1'b1;
      end
      if (frame_end && !s_axis_tlast) begin
        err_long_d = 1'b1;
      end
    end

    if (out_valid && x_TREADY && out_word.last) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q      <= '0;
      elem_cnt_q  <= '0;
      asm_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      lane_q      <= lane_d;
      elem_cnt_q  <= elem_cnt_d;
      asm_q       <= asm_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign load_word.last = close_last;
  assign load_word.data = merged;

  mm_axis_outreg #(
    .W ($bits(axis_word_t))
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (close),
    .load_data (load_word),
    .in_ready  (out_ready_up),
    .out_valid (out_valid),
    .out_data  (out_word),
    .out_ready (x_TREADY)
  );

  assign x_TVALID  = out_valid;
  assign x_TDATA   = out_word.data;
  assign x_TLAST   = out_word.last;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mm_axis_packer.sv
// Directed bench: default packer (32-element frames) plus a 6-element-frame
// instance for the unaligned case; shared source data and downstream ready.
module tb_mm_axis_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tlast;
  logic        va, vb;
  logic        x_TREADY;

  logic        a_tready, a_tvalid, a_tlast, a_err_s, a_err_l;
  logic [31:0] a_tdata;
  logic [15:0] a_fcnt;
  logic        b_tready, b_tvalid, b_tlast, b_err_s, b_err_l;
  logic [31:0] b_tdata;
  logic [15:0] b_fcnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          bp       = 0;
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] exp_q[$];
  int          qa_size;

  logic        pa_v, pa_r;
  logic [32:0] pa_w;

  mm_axis_packer dut_a (
    .clk (clk), .rst_n (rst_n),
    .s_axis_tdata (s_tdata), .s_axis_tvalid (va), .s_axis_tready (a_tready),
    .s_axis_tlast (s_tlast),
    .x_TDATA (a_tdata), .x_TVALID (a_tvalid), .x_TREADY (x_TREADY), .x_TLAST (a_tlast),
    .err_short (a_err_s), .err_long (a_err_l), .frame_cnt (a_fcnt)
  );

  mm_axis_packer #(.FRAME_ELEMS(6)) dut_b (
    .clk (clk), .rst_n (rst_n),
    .s_axis_tdata (s_tdata), .s_axis_tvalid (vb), .s_axis_tready (b_tready),
    .s_axis_tlast (s_tlast),
    .x_TDATA (b_tdata), .x_TVALID (b_tvalid), .x_TREADY (x_TREADY), .x_TLAST (b_tlast),
    .err_short (b_err_s), .err_long (b_err_l), .frame_cnt (b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Capture handshaken words, check stall hold and the ready relation.
  always @(negedge clk) begin
    if (!rst_n) begin
      pa_v = 1'b0;
    end else begin
      if (pa_v && !pa_r) begin
        chk("stall_hold", {a_tvalid, a_tlast, a_tdata}, {1'b1, pa_w});
      end
      chk("s_tready_rel", a_tready, !(a_tvalid && !x_TREADY));
      if (a_tvalid && x_TREADY) qa.push_back({a_tlast, a_tdata});
      if (b_tvalid && x_TREADY) qb.push_back({b_tlast, b_tdata});
      pa_v = a_tvalid;
      pa_r = x_TREADY;
      pa_w = {a_tlast, a_tdata};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    x_TREADY = bp ? (cyc % 4 == 0) : 1'b1;
  endtask

  task automatic send(input bit sel_b, input logic [7:0] d, input logic l);
    bit acc;
    acc     = 1'b0;
    s_tdata = d;
    s_tlast = l;
    va      = !sel_b;
    vb      = sel_b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = sel_b ? b_tready : a_tready;
      step();
    end
    if (!acc) chk("accept_timeout", 0, 1);
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic check_words(input string tag, input logic [32:0] got[$],
                             input logic [32:0] exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_w%0d", tag, i), got[i], exp[i]);
    end
  endtask

  function automatic logic [32:0] wd(input logic last, input int b0);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = 8'(b0 + i);
    return {last, b[3], b[2], b[1], b[0]};
  endfunction

  initial begin
    rst_n    = 1'b1;
    va       = 1'b0;
    vb       = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    x_TREADY = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", a_tvalid, 0);
    chk("rst_data",  a_tdata, 0);
    chk("rst_last",  a_tlast, 0);
    chk("rst_fcnt",  a_fcnt, 0);
    chk("rst_errs",  {a_err_s, a_err_l}, 0);
    chk("rst_ready", a_tready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drain(1);

    // Full frame, downstream always ready.
    qa.delete();
    for (int i = 0; i < 32; i++) send(0, 8'(i), i == 31);
    drain(4);
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(wd(k == 7, 4 * k));
    check_words("full", qa, exp_q);
    chk("full_fcnt", a_fcnt, 1);
    chk("full_errs", {a_err_s, a_err_l}, 0);

    // Same frame under 1-on/3-off backpressure.
    qa.delete();
    bp = 1;
    for (int i = 0; i < 32; i++) send(0, 8'(i), i == 31);
    drain(24);
    bp = 0;
    drain(2);
    check_words("bp", qa, exp_q);
    chk("bp_fcnt", a_fcnt, 2);

    // Short frame closed early by source tlast.
    qa.delete();
    for (int i = 0; i < 6; i++) send(0, 8'(8'hA0 + i), i == 5);
    drain(4);
    exp_q.delete();
    exp_q.push_back({1'b0, 32'hA3A2A1A0});
    exp_q.push_back({1'b1, 32'h0000A5A4});
    check_words("short", qa, exp_q);
    chk("short_err_s", a_err_s, 1);
    chk("short_err_l", a_err_l, 0);
    chk("short_fcnt", a_fcnt, 3);

    // Missing tlast: frame closes at 32, element 33 starts a new frame.
    qa.delete();
    for (int i = 0; i < 36; i++) send(0, 8'(i), 1'b0);
    drain(4);
    exp_q.delete();
    for (int k = 0; k < 9; k++) exp_q.push_back(wd(k == 7, 4 * k));
    check_words("long", qa, exp_q);
    chk("long_err_l", a_err_l, 1);
    chk("long_err_s_sticky", a_err_s, 1);
    chk("long_fcnt", a_fcnt, 4);

    // Reset mid-frame: partial word 0x44 must be discarded.
    for (int i = 0; i < 5; i++) send(0, 8'(8'h40 + i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", a_tvalid, 0);
    chk("mrst_data",  a_tdata, 0);
    chk("mrst_last",  a_tlast, 0);
    chk("mrst_fcnt",  a_fcnt, 0);
    chk("mrst_errs",  {a_err_s, a_err_l}, 0);
    chk("mrst_ready", a_tready, 1);
    drain(2);
    rst_n = 1'b1;
    qa.delete();
    drain(3);
    chk("mrst_no_stale", qa.size(), 0);
    for (int i = 0; i < 4; i++) send(0, 8'(8'h50 + i), 1'b0);
    drain(3);
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h53525150});
    check_words("mrst_fresh", qa, exp_q);

    // Unaligned 6-element frames on the second instance.
    qb.delete();
    for (int i = 0; i < 6; i++) send(1, 8'(8'h10 + i), i == 5);
    for (int i = 0; i < 6; i++) send(1, 8'(8'h20 + i), i == 5);
    drain(4);
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h13121110});
    exp_q.push_back({1'b1, 32'h00001514});
    exp_q.push_back({1'b0, 32'h23222120});
    exp_q.push_back({1'b1, 32'h00002524});
    check_words("unal", qb, exp_q);
    chk("unal_fcnt", b_fcnt, 2);
    chk("unal_errs", {b_err_s, b_err_l}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
